// File: rtl/ecc_pkg.sv
// Shared types and page geometry for the ECC flash path: page sizes, byte/address
// types, the page-port FSM states and the injection-slot helper.
package ecc_pkg;

    localparam int DATA_BYTES  = 512;
    localparam int SPARE_BYTES = 16;
    localparam int PAGE_BYTES  = DATA_BYTES + SPARE_BYTES;
    localparam int ADRS_W      = 10;

    typedef logic [7:0]        byte_t;
    typedef logic [ADRS_W-1:0] page_adrs_t;

    typedef enum logic [1:0] {
        IDLE,
        CAPTURE,
        PLAY
    } fpp_state_t;

    localparam page_adrs_t LAST_ADRS = page_adrs_t'(PAGE_BYTES - 1);
    localparam byte_t      ERASED    = 8'hFF;

    // XOR contribution of one injection slot to playback byte k.
    function automatic byte_t inj_term(logic en, page_adrs_t slot_adrs, byte_t mask, page_adrs_t k);
        return (en && (slot_adrs == k)) ? mask : 8'h00;
    endfunction

endpackage

// File: rtl/flash_page_port_if.sv
// Byte interface between eccCntl (master) and the flash page port (slave),
// including the playback injection controls and status.
interface flash_page_port_if;
    import ecc_pkg::*;

    logic       flashDataValid;
    byte_t      flashDi;
    logic       wrStart;
    logic       rdStart;
    logic [1:0] injEn;
    page_adrs_t injAdrs0;
    page_adrs_t injAdrs1;
    byte_t      injMask0;
    byte_t      injMask1;
    byte_t      flashDo;
    logic       flashDoValid;
    logic       busy;
    logic       pageValid;
    page_adrs_t wrCount;
    logic       dropErr;

    modport master (
        output flashDataValid, flashDi, wrStart, rdStart,
               injEn, injAdrs0, injAdrs1, injMask0, injMask1,
        input  flashDo, flashDoValid, busy, pageValid, wrCount, dropErr
    );

    modport slave (
        input  flashDataValid, flashDi, wrStart, rdStart,
               injEn, injAdrs0, injAdrs1, injMask0, injMask1,
        output flashDo, flashDoValid, busy, pageValid, wrCount, dropErr
    );

endinterface

// File: rtl/flash_page_mem.sv
// Page storage: PAGE_BYTES x 8 with one synchronous write port and one
// synchronous, registered read port.
module flash_page_mem
    import ecc_pkg::*;
(
    input  logic       clk,
    input  logic       we_i,
    input  page_adrs_t wadrs_i,
    input  byte_t      wdata_i,
    input  logic       re_i,
    input  page_adrs_t radrs_i,
    output byte_t      rdata_o
);

    byte_t mem_q [PAGE_BYTES];
    byte_t rdata_q;

    // NOTE: array and read register carry no reset so this maps onto block RAM;
    // stale contents are masked upstream by the wrCount compare.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[wadrs_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[radrs_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/flash_page_port.sv
// Flash-side endpoint for eccCntl: captures one encoded page and replays it
// with optional XOR error injection on up to two byte addresses.
module flash_page_port
    import ecc_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    flash_page_port_if.slave fpp
);

    fpp_state_t state_q;
    page_adrs_t wr_count_q;
    page_adrs_t rd_ptr_q;
    logic       page_valid_q;
    logic       drop_err_q;
    logic       do_valid_q;
    logic [1:0] inj_en_q;
    page_adrs_t inj_adrs0_q;
    page_adrs_t inj_adrs1_q;
    byte_t      inj_mask0_q;
    byte_t      inj_mask1_q;

    logic       mem_we;
    logic       mem_re;
    page_adrs_t mem_radrs;
    byte_t      mem_rdata;
    byte_t      do_byte_d;

    assign mem_we = (state_q == CAPTURE) && !fpp.wrStart && fpp.flashDataValid;

    // Read address runs one ahead of rd_ptr_q, so mem_rdata holds byte k while rd_ptr_q == k.
    assign mem_re    = (state_q == IDLE) || ((state_q == PLAY) && (rd_ptr_q != LAST_ADRS));
    assign mem_radrs = (state_q == PLAY) ? rd_ptr_q + 1'b1 : '0;

    flash_page_mem u_mem (
        .clk     (clk),
        .we_i    (mem_we),
        .wadrs_i (wr_count_q),
        .wdata_i (fpp.flashDi),
        .re_i    (mem_re),
        .radrs_i (mem_radrs),
        .rdata_o (mem_rdata)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            wr_count_q   <= '0;
            rd_ptr_q     <= '0;
            page_valid_q <= 1'b0;
            drop_err_q   <= 1'b0;
            do_valid_q   <= 1'b0;
            inj_en_q     <= '0;
            inj_adrs0_q  <= '0;
            inj_adrs1_q  <= '0;
            inj_mask0_q  <= '0;
            inj_mask1_q  <= '0;
        end else begin
            if (fpp.flashDataValid && (state_q != CAPTURE)) begin
                drop_err_q <= 1'b1;
            end
            unique case (state_q)
                IDLE: begin
                    if (fpp.wrStart) begin
                        state_q      <= CAPTURE;
                        wr_count_q   <= '0;
                        page_valid_q <= 1'b0;
                    end else if (fpp.rdStart) begin
                        state_q     <= PLAY;
                        rd_ptr_q    <= '0;
                        do_valid_q  <= 1'b1;
                        inj_en_q    <= fpp.injEn;
                        inj_adrs0_q <= fpp.injAdrs0;
                        inj_adrs1_q <= fpp.injAdrs1;
                        inj_mask0_q <= fpp.injMask0;
                        inj_mask1_q <= fpp.injMask1;
                    end
                end
                CAPTURE: begin
                    if (fpp.wrStart) begin
                        wr_count_q   <= '0;
                        page_valid_q <= 1'b0;
                    end else if (fpp.flashDataValid) begin
                        wr_count_q <= wr_count_q + 1'b1;
                        if (wr_count_q == LAST_ADRS) begin
                            page_valid_q <= 1'b1;
                            state_q      <= IDLE;
                        end
                    end
                end
                PLAY: begin
                    if (fpp.wrStart) begin
                        state_q      <= CAPTURE;
                        wr_count_q   <= '0;
                        page_valid_q <= 1'b0;
                        do_valid_q   <= 1'b0;
                    end else if (rd_ptr_q == LAST_ADRS) begin
                        state_q    <= IDLE;
                        do_valid_q <= 1'b0;
                    end else begin
                        rd_ptr_q <= rd_ptr_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Byte k must appear right after edge E0+k, so the output is a mux over registered
    // state and the registered RAM read rather than a further pipeline stage.
    always_comb begin
        // NOTE: default first so every path assigns do_byte_d and no latch is inferred.
        do_byte_d = ERASED;
        if (do_valid_q) begin
            do_byte_d = (rd_ptr_q < wr_count_q) ? mem_rdata : ERASED;
            do_byte_d = do_byte_d
                      ^ inj_term(inj_en_q[0], inj_adrs0_q, inj_mask0_q, rd_ptr_q)
                      ^ inj_term(inj_en_q[1], inj_adrs1_q, inj_mask1_q, rd_ptr_q);
        end
    end

    assign fpp.flashDo      = do_byte_d;
    assign fpp.flashDoValid = do_valid_q;
    assign fpp.busy         = (state_q != IDLE);
    assign fpp.pageValid    = page_valid_q;
    assign fpp.wrCount      = wr_count_q;
    assign fpp.dropErr      = drop_err_q;

endmodule

// File: tb/tb_flash_page_port.sv
// Self-checking bench for flash_page_port: a page-level model (array + playback
// queue) is compared against the DUT every cycle, plus literal spot checks.
module tb_flash_page_port;
    import ecc_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    flash_page_port_if bus ();

    flash_page_port dut (
        .clk   (clk),
        .reset (reset),
        .fpp   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    byte_t m_mem [PAGE_BYTES];
    int    m_mode;            // 0 idle, 1 capturing, 2 playing
    int    m_wr;
    bit    m_pv;
    bit    m_drop;
    byte_t play_q [$];
    byte_t e_do;
    bit    e_dov;
    byte_t b;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_mode = 0; m_wr = 0; m_pv = 0; m_drop = 0;
            play_q.delete(); e_do = 8'hFF; e_dov = 0;
        end else begin
            if (bus.flashDataValid && m_mode != 1) m_drop = 1;
            case (m_mode)
                0: begin
                    if (bus.wrStart) begin
                        m_mode = 1; m_wr = 0; m_pv = 0;
                    end else if (bus.rdStart) begin
                        play_q.delete();
                        for (int k = 0; k < PAGE_BYTES; k++) begin
                            b = (k < m_wr) ? m_mem[k] : 8'hFF;
                            if (bus.injEn[0] && int'(bus.injAdrs0) == k) b = b ^ bus.injMask0;
                            if (bus.injEn[1] && int'(bus.injAdrs1) == k) b = b ^ bus.injMask1;
                            play_q.push_back(b);
                        end
                        m_mode = 2;
                        e_do   = play_q.pop_front();
                        e_dov  = 1;
                    end
                end
                1: begin
                    if (bus.wrStart) begin
                        m_wr = 0; m_pv = 0;
                    end else if (bus.flashDataValid) begin
                        m_mem[m_wr] = bus.flashDi;
                        m_wr++;
                        if (m_wr == PAGE_BYTES) begin
                            m_pv = 1; m_mode = 0;
                        end
                    end
                end
                default: begin
                    if (bus.wrStart) begin
                        m_mode = 1; m_wr = 0; m_pv = 0;
                        play_q.delete(); e_do = 8'hFF; e_dov = 0;
                    end else if (play_q.size() == 0) begin
                        m_mode = 0; e_do = 8'hFF; e_dov = 0;
                    end else begin
                        e_do = play_q.pop_front();
                    end
                end
            endcase
        end
    end

    // ---------------- per-cycle compare + playback capture ----------------
    byte_t obs [PAGE_BYTES + 8];
    int    obs_n = 0;

    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (reset) begin
                check("flashDoValid", bus.flashDoValid, e_dov);
                check("flashDo",      bus.flashDo,      e_do);
                check("busy",         bus.busy,         (m_mode != 0));
                check("pageValid",    bus.pageValid,    m_pv);
                check("wrCount",      bus.wrCount,      m_wr);
                check("dropErr",      bus.dropErr,      m_drop);
                if (bus.flashDoValid === 1'b1) begin
                    if (obs_n < PAGE_BYTES + 8) obs[obs_n] = bus.flashDo;
                    obs_n++;
                end
            end
        end
    end

    // ---------------- stimulus helpers (drive on negedge) ----------------
    task automatic idle_inputs();
        bus.flashDataValid = 0; bus.flashDi = '0;
        bus.wrStart = 0; bus.rdStart = 0; bus.injEn = '0;
        bus.injAdrs0 = '0; bus.injAdrs1 = '0; bus.injMask0 = '0; bus.injMask1 = '0;
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_wr();
        bus.wrStart = 1;
        @(negedge clk);
        bus.wrStart = 0;
    endtask

    // gap_mode: 0 contiguous, 1 every other cycle, 2 random gaps with stray rdStart
    task automatic send_bytes(input int n, input int gap_mode, input bit rnd);
        for (int k = 0; k < n; k++) begin
            if (gap_mode == 1 && k > 0) cyc(1);
            if (gap_mode == 2) cyc($urandom_range(0, 2));
            bus.flashDataValid = 1;
            bus.flashDi = rnd ? byte_t'($urandom) : (byte_t'(k) ^ 8'h5A);
            bus.rdStart = (gap_mode == 2) && ($urandom_range(0, 15) == 0);
            @(negedge clk);
            bus.flashDataValid = 0;
            bus.rdStart = 0;
        end
    endtask

    task automatic read_page(input logic [1:0] en, input page_adrs_t a0, input page_adrs_t a1,
                             input byte_t m0, input byte_t m1);
        bus.injEn = en; bus.injAdrs0 = a0; bus.injAdrs1 = a1;
        bus.injMask0 = m0; bus.injMask1 = m1;
        bus.rdStart = 1;
        obs_n = 0;
        @(negedge clk);
        bus.rdStart = 0;
        // scramble the slot inputs: they must only matter at rdStart
        bus.injEn = 2'($urandom); bus.injAdrs0 = page_adrs_t'($urandom);
        bus.injMask0 = byte_t'($urandom); bus.injMask1 = byte_t'($urandom);
        cyc(PAGE_BYTES + 2);
        idle_inputs();
    endtask

    function automatic page_adrs_t rand_adrs();
        return ($urandom_range(0, 3) == 0) ? page_adrs_t'($urandom) : page_adrs_t'($urandom_range(0, PAGE_BYTES - 1));
    endfunction

    // ---------------- test sequence ----------------
    initial begin
        int nff;
        int n_valid;
        page_adrs_t ra0;
        page_adrs_t ra1;
        idle_inputs();
        #1;
        check("reset flashDo",      bus.flashDo,      8'hFF);
        check("reset flashDoValid", bus.flashDoValid, 0);
        check("reset busy",         bus.busy,         0);
        check("reset pageValid",    bus.pageValid,    0);
        check("reset wrCount",      bus.wrCount,      0);
        check("reset dropErr",      bus.dropErr,      0);
        cyc(2);
        reset = 1;
        cyc(2);

        // 1: contiguous full page
        pulse_wr();
        send_bytes(PAGE_BYTES, 0, 0);
        check("t1 wrCount",   bus.wrCount,   528);
        check("t1 pageValid", bus.pageValid, 1);
        check("t1 busy",      bus.busy,      0);

        // 2: clean readback
        read_page(2'b00, '0, '0, '0, '0);
        check("t2 valid count", obs_n,   528);
        check("t2 byte0",       obs[0],   8'h5A);
        check("t2 byte300",     obs[300], 8'h76);
        check("t2 byte527",     obs[527], 8'h55);

        // 3: two-slot injection, then clean again
        read_page(2'b11, 10'd12, 10'd171, 8'hFF, 8'hFF);
        check("t3 byte12 inj",  obs[12],  8'hA9);
        check("t3 byte13",      obs[13],  8'h57);
        check("t3 byte171 inj", obs[171], 8'h0E);
        read_page(2'b00, '0, '0, '0, '0);
        check("t3 byte12 clean", obs[12], 8'h56);

        // 4: gapped capture, then a stray byte after completion
        pulse_wr();
        send_bytes(PAGE_BYTES, 1, 0);
        bus.flashDataValid = 1; bus.flashDi = 8'h33;
        cyc(1);
        bus.flashDataValid = 0;
        cyc(1);
        check("t4 dropErr", bus.dropErr, 1);
        check("t4 wrCount", bus.wrCount, 528);
        read_page(2'b00, '0, '0, '0, '0);
        check("t4 byte0", obs[0], 8'h5A);

        // 6: reset during playback byte 200
        bus.rdStart = 1;
        @(negedge clk);
        bus.rdStart = 0;
        repeat (200) @(posedge clk);
        #3;
        check("t6 byte200 before reset", bus.flashDo, 8'h92);
        reset = 0;
        #1;
        check("t6 reset flashDoValid", bus.flashDoValid, 0);
        check("t6 reset flashDo",      bus.flashDo,      8'hFF);
        check("t6 reset busy",         bus.busy,         0);
        check("t6 reset wrCount",      bus.wrCount,      0);
        check("t6 reset dropErr",      bus.dropErr,      0);
        cyc(2);
        reset = 1;
        cyc(1);
        read_page(2'b00, '0, '0, '0, '0);
        nff = 0;
        for (int k = 0; k < PAGE_BYTES; k++) if (obs[k] === 8'hFF) nff++;
        check("t6 erased bytes", nff, 528);
        bus.wrStart = 1; bus.rdStart = 1;
        @(negedge clk);
        bus.wrStart = 0; bus.rdStart = 0;
        check("t6 wr+rd busy",    bus.busy,         1);
        check("t6 wr+rd doValid", bus.flashDoValid, 0);
        check("t6 wr+rd wrCount", bus.wrCount,      0);

        // 5: partial capture; rdStart is ignored while capturing
        pulse_wr();
        send_bytes(100, 0, 0);
        bus.rdStart = 1;
        @(negedge clk);
        bus.rdStart = 0;
        cyc(3);
        check("t5 wrCount",   bus.wrCount,   100);
        check("t5 pageValid", bus.pageValid, 0);
        check("t5 busy",      bus.busy,      1);
        check("t5 no playback", obs_n - 528, 0);
        reset = 0;
        cyc(1);
        reset = 1;
        cyc(1);
        read_page(2'b01, 10'd99, 10'd0, 8'h0F, 8'h00);
        check("t5 byte99 erased+mask", obs[99],  8'hF0);
        check("t5 byte100 erased",     obs[100], 8'hFF);

        // random pages, random injection, random abort of playback
        for (int it = 0; it < 4; it++) begin
            pulse_wr();
            send_bytes(PAGE_BYTES, 2, 1);
            cyc($urandom_range(0, 3));
            ra0 = rand_adrs();
            ra1 = ($urandom_range(0, 3) == 0) ? ra0 : rand_adrs();
            read_page(2'($urandom), ra0, ra1, byte_t'($urandom), byte_t'($urandom));
            check("rnd valid count", obs_n, 528);
        end
        bus.rdStart = 1;
        @(negedge clk);
        bus.rdStart = 0;
        cyc($urandom_range(10, 500));
        pulse_wr();
        check("abort doValid", bus.flashDoValid, 0);
        check("abort flashDo", bus.flashDo,      8'hFF);
        n_valid = 0;
        send_bytes(PAGE_BYTES, 0, 1);
        read_page(2'b00, '0, '0, '0, '0);
        check("abort reread count", obs_n, 528);

        cyc(2);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
